// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioning blocks.
package btn_pkg;

   typedef enum logic [1:0] {
      REP_IDLE       = 2'd0,
      REP_WAIT_DELAY = 2'd1,
      REP_REPEATING  = 2'd2
   } rep_state_e;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, counter debouncer, press/release strobes and
// hold-to-repeat FSM.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYC   = 20000,
   parameter int REPEAT_DELAY   = 500000,
   parameter int REPEAT_RATE    = 100000,
   parameter bit RAW_ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel,
   output logic rpt
);

   localparam int DW = cnt_width(DEBOUNCE_CYC);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC);

   logic          s1;
   logic          s2;
   logic          s;
   logic [DW-1:0] deb_cnt;
   logic          flip;

   // Reset loads the inactive pin level so releasing reset cannot fake an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= RAW_ACTIVE_LOW;
         s2 <= RAW_ACTIVE_LOW;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   assign s    = s2 ^ RAW_ACTIVE_LOW;
   assign flip = (s != level) && (deb_cnt == DEB_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
         rel     <= 1'b0;
      end else begin
         press <= flip & ~level;
         rel   <= flip & level;
         if (s == level) begin
            deb_cnt <= '0;
         end else if (flip) begin
            deb_cnt <= '0;
            level   <= ~level;
         end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   generate
      if (REPEAT_RATE == 0) begin : g_no_rep
         assign rpt = 1'b0;
      end else begin : g_rep
         localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
         localparam logic [RW-1:0] DELAY_N = RW'(REPEAT_DELAY);
         localparam logic [RW-1:0] RATE_N  = RW'(REPEAT_RATE);
         localparam logic [RW-1:0] ONE     = RW'(1);

         rep_state_e    state;
         logic [RW-1:0] rep_cnt;

         // rep_cnt counts cycles since the last press/repeat strobe, starting at 1
         // in the strobe cycle, so a match fires the strobe exactly N cycles later.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state   <= REP_IDLE;
               rep_cnt <= '0;
               rpt     <= 1'b0;
            end else begin
               rpt <= 1'b0;
               if (flip && level) begin
                  state   <= REP_IDLE;
                  rep_cnt <= '0;
               end else if (flip) begin
                  state   <= REP_WAIT_DELAY;
                  rep_cnt <= ONE;
               end else begin
                  case (state)
                     REP_WAIT_DELAY: begin
                        if (rep_cnt >= DELAY_N) begin
                           state   <= REP_REPEATING;
                           rep_cnt <= ONE;
                           rpt     <= 1'b1;
                        end else begin
                           rep_cnt <= rep_cnt + 1'b1;
                        end
                     end
                     REP_REPEATING: begin
                        if (rep_cnt >= RATE_N) begin
                           rep_cnt <= ONE;
                           rpt     <= 1'b1;
                        end else begin
                           rep_cnt <= rep_cnt + 1'b1;
                        end
                     end
                     default: begin
                        state   <= REP_IDLE;
                        rep_cnt <= '0;
                     end
                  endcase
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/button_conditioner.sv
// N independent button channels between the board pins and the mode/edit FSMs.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN          = 4,
   parameter int DEBOUNCE_CYC   = 20000,
   parameter int REPEAT_DELAY   = 500000,
   parameter int REPEAT_RATE    = 100000,
   parameter bit RAW_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYC   (DEBOUNCE_CYC),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE),
         .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_release[i]),
         .rpt   (btn_repeat[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner with a cycle-level reference model.
module tb_button_conditioner;

   localparam int N    = 4;
   localparam int DEB  = 4;
   localparam int DLY  = 10;
   localparam int RATE = 3;
   localparam int W    = 32 + 3 * N;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
   logic [0:0]   raw2;
   logic [0:0]   level2, press2, rel2, rpt2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   logic [N-1:0] hist_q[$];
   logic [N-1:0] m_level;
   int           next_rep[N];

   int p2_cnt = 0, p2_cyc = -1, r2_cnt = 0, rel2_cnt = 0;

   button_conditioner #(
      .N_BTN(N), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .RAW_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   button_conditioner #(
      .N_BTN(1), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(0), .RAW_ACTIVE_LOW(1'b1)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_raw(raw2), .btn_level(level2),
      .btn_press(press2), .btn_release(rel2), .btn_repeat(rpt2)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      m_level = '0;
      exp_q.delete();
      hist_q.delete();
      for (int k = 0; k <= DEB; k++) hist_q.push_back('0);
      for (int ch = 0; ch < N; ch++) next_rep[ch] = -1;
   endfunction

   // Reference: a level is accepted once the raw samples taken 2..DEB+1 edges ago all
   // disagree with it; repeats are scheduled from the press cycle.
   initial begin : model
      logic [N-1:0] p, r, rp;
      bit           all_new;
      model_clear();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            model_clear();
         end else begin
            p = '0; r = '0; rp = '0;
            for (int ch = 0; ch < N; ch++) begin
               all_new = 1'b1;
               for (int k = 0; k < DEB; k++)
                  if (hist_q[k][ch] == m_level[ch]) all_new = 1'b0;
               if (all_new) begin
                  if (m_level[ch]) begin
                     r[ch] = 1'b1;
                     next_rep[ch] = -1;
                  end else begin
                     p[ch] = 1'b1;
                     next_rep[ch] = cyc + DLY;
                  end
                  m_level[ch] = ~m_level[ch];
               end else if (next_rep[ch] == cyc) begin
                  rp[ch] = 1'b1;
                  next_rep[ch] = cyc + RATE;
               end
            end
            hist_q.push_back(btn_raw);
            if (hist_q.size() > DEB + 1) void'(hist_q.pop_front());
            if ((p | r | rp) != '0) exp_q.push_back({32'(cyc), p, r, rp});
         end
      end
   end

   // Monitor / scoreboard
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("level", btn_level, m_level);
            if ((btn_press | btn_release | btn_repeat) != '0 ||
                (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) <= cyc)) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_strobe", {btn_press, btn_release, btn_repeat}, 64'd0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("strobe_cycle", 64'(cyc), 64'(mon_e[W-1 -: 32]));
                  check("press", btn_press, mon_e[3*N-1 -: N]);
                  check("release", btn_release, mon_e[2*N-1 -: N]);
                  check("repeat", btn_repeat, mon_e[N-1:0]);
               end
            end
            if (press2[0]) begin p2_cnt++; p2_cyc = cyc; end
            if (rpt2[0]) r2_cnt++;
            if (rel2[0]) rel2_cnt++;
         end
      end
   end

   // Stimulus
   initial begin : driver
      int c;
      rst_n   = 1'b0;
      btn_raw = '1;
      raw2    = 1'b1;
      tick(3);
      check("reset_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 64'd0);
      rst_n = 1'b1;
      tick(5);
      check("reset_hold_level", btn_level, 64'd0);
      tick(1);
      check("reset_accept_level", btn_level, 64'hF);
      check("reset_accept_press", btn_press, 64'hF);
      check("dut2_idle_level", level2, 64'd0);
      tick(20);
      btn_raw = '0;
      tick(15);

      // clean press on ch3
      btn_raw[3] = 1'b1;
      tick(30);
      btn_raw[3] = 1'b0;
      tick(15);

      // bounce on ch2, then a short glitch while held
      for (int k = 0; k < 2; k++) begin
         btn_raw[2] = 1'b1; tick(2);
         btn_raw[2] = 1'b0; tick(2);
      end
      btn_raw[2] = 1'b1; tick(20);
      btn_raw[2] = 1'b0; tick(3);
      btn_raw[2] = 1'b1; tick(15);
      btn_raw[2] = 1'b0; tick(15);

      // simultaneous press, partial release
      btn_raw[1:0] = 2'b11; tick(25);
      btn_raw[1]   = 1'b0;  tick(20);
      btn_raw[0]   = 1'b0;  tick(15);

      // active-low, repeat-disabled instance
      raw2 = 1'b0;
      c = cyc;
      tick(40);
      check("dut2_press_count", 64'(p2_cnt), 64'd1);
      check("dut2_press_cycle", 64'(p2_cyc), 64'(c + DEB + 2));
      check("dut2_repeat_count", 64'(r2_cnt), 64'd0);
      check("dut2_level_held", level2, 64'd1);
      raw2 = 1'b1;
      tick(10);
      check("dut2_release_count", 64'(rel2_cnt), 64'd1);
      check("dut2_level_released", level2, 64'd0);

      // reset while ch3 is repeating
      btn_raw[3] = 1'b1;
      tick(22);
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 64'd0);
      tick(3);
      rst_n = 1'b1;
      c = cyc;
      tick(5);
      check("rearm_level_low", btn_level[3], 64'd0);
      tick(1);
      check("rearm_level_high", btn_level[3], 64'd1);
      check("rearm_press", btn_press[3], 64'd1);
      tick(DLY);
      check("rearm_first_repeat", btn_repeat[3], 64'd1);
      check("rearm_elapsed", 64'(cyc - c), 64'(DEB + 2 + DLY));
      tick(5);
      btn_raw[3] = 1'b0;
      tick(15);

      // random traffic: frequent glitches, then longer holds
      for (int t = 0; t < 600; t++) begin
         for (int ch = 0; ch < N; ch++)
            if ($urandom_range(0, (t < 300) ? 7 : 29) == 0) btn_raw[ch] = ~btn_raw[ch];
         tick(1);
      end
      btn_raw = '0;
      tick(20);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
